cb_cfg_shadow_param: RTL and testbench
======================================

Name: cb_cfg_shadow_param

Overview:
Parametrised connection block for the routing fabric. It passes CHAN_W left/right channel tracks straight through and drives NUM_IPIN grid input pins, each through a configurable track-select mux. Configuration uses the standard ccff scan chain. A new shadow/commit stage means mux selections change atomically, and only after a complete, counted load. A bit counter, load state machine, valid flag and sticky error flag support partial-reconfiguration control.

Parameters:
CHAN_W, 3, tracks per direction; legal range 1..16
NUM_IPIN, 4, number of grid input pins driven
SEL_W, 3, select bits per ipin; elaboration fails unless 2**SEL_W > 2*CHAN_W
CNT_W, 5, cfg_count width; elaboration fails unless 2**CNT_W > NUM_IPIN*SEL_W

Ports:
prog_clk  input  1  configuration clock; all state updates on its rising edge
prog_reset  input  1  asynchronous, active-high reset
ccff_en  input  1  shift enable for the scan chain
ccff_head  input  1  scan-chain serial input
ccff_commit  input  1  single-cycle request to copy the scan chain into the active selects
chanx_left_in  input  CHAN_W  tracks entering from left
chanx_right_in  input  CHAN_W  tracks entering from right
chanx_left_out  output  CHAN_W  equals chanx_right_in, combinational
chanx_right_out  output  CHAN_W  equals chanx_left_in, combinational
ipin_out  output  NUM_IPIN  grid input pins
ccff_tail  output  1  scan-chain serial output
cfg_count  output  CNT_W  bits shifted since the last reset or commit, saturating
cfg_full  output  1  high when cfg_count == N
cfg_valid  output  1  high once at least one successful commit has occurred
cfg_err  output  1  sticky illegal-commit flag

Behaviour:
- N = NUM_IPIN*SEL_W. Scan register sr[0..N-1]; active select register act[0..N-1].
- Shift, when ccff_en=1: sr[0]<=ccff_head; sr[i]<=sr[i-1]. ccff_tail = sr[N-1], registered, so the chain adds exactly N cycles of latency. With ccff_en=0, sr holds.
- Select mapping: sel_j bit b = act[j*SEL_W+b] (j = 0..NUM_IPIN-1). The first bit shifted in ends at sr[N-1], i.e. MSB of ipin NUM_IPIN-1.
- Mux input index k: even k=2t selects chanx_left_in[t]; odd k=2t+1 selects chanx_right_in[t].
- ipin_out[j] = input[sel_j] if sel_j < 2*CHAN_W, else 0 (disabled).
- Mux path is purely combinational from inputs and act. ipin_out never reflects sr directly.
- Load FSM, derived from cfg_count:
  - IDLE: count = 0.
  - LOADING: 0 < count < N.
  - FULL: count = N.
- Each shift increments cfg_count, saturating at N. Shifting while FULL keeps passing bits downstream and stays FULL; act tracks the last N bits at commit time.
- Commit, when ccff_commit=1 and ccff_en=0:
  - If FULL: act<=sr; cfg_count<=0 (IDLE); cfg_valid<=1.
  - Otherwise: no act update, count unchanged, cfg_err<=1.
- ccff_commit=1 with ccff_en=1 in the same cycle is illegal: the shift is performed, the commit is ignored, and cfg_err<=1.
- cfg_err and cfg_valid clear only on prog_reset.
- Reset, asynchronous, takes effect immediately including mid-load:
  - sr = 0; act = all ones (every ipin disabled, ipin_out = 0).
  - cfg_count = 0; cfg_full = 0; cfg_valid = 0; cfg_err = 0; ccff_tail = 0.
- Reset dominates ccff_en and ccff_commit. Pass-through channel outputs are unaffected by reset.

Test Plan:
- Reset (defaults, N=12): assert prog_reset mid-load after 5 shifts -> cfg_count=0 and ipin_out=0 immediately; after release, cfg_valid=0 and ccff_tail=0.
- Full load and commit:
  - Shift 12 bits so that sel_0=0, sel_1=3, sel_2=4, sel_3=7.
  - Before commit: ipin_out stays 0.
  - Pulse commit -> chanx_left_in[0] appears on ipin_out[0], chanx_right_in[1] on ipin_out[1], chanx_left_in[2] on ipin_out[2]; ipin_out[3]=0; cfg_valid=1; cfg_count=0.
- Premature commit: shift 7 bits, then commit -> act unchanged, cfg_err=1, cfg_count=7. Finish 5 more shifts and commit -> act updates; cfg_err remains 1.
- Overshift and tail: shift 15 bits -> cfg_count saturates at 12. The first 3 bits shifted appear on ccff_tail on shift cycles 13..15, in order. Commit loads the last 12 bits.
- Simultaneous events: ccff_en=1 with ccff_commit=1 while FULL -> shift occurs, act unchanged, cfg_err=1.
- Pass-through and disable codes: toggle every channel input -> outputs follow in the same cycle. Commit sel=6 and sel=7 on all ipins -> all ipin_out=0.

Source files
------------

// File: rtl/cb_cfg_shadow_param.sv
// rtl/cb_cfg_shadow_param.sv - connection block with counted scan-chain load and atomic shadow commit
module cb_cfg_shadow_param #(
    parameter int CHAN_W   = 3,
    parameter int NUM_IPIN = 4,
    parameter int SEL_W    = 3,
    parameter int CNT_W    = 5
) (
    input  logic                prog_clk,
    input  logic                prog_reset,
    input  logic                ccff_en,
    input  logic                ccff_head,
    input  logic                ccff_commit,
    input  logic [CHAN_W-1:0]   chanx_left_in,
    input  logic [CHAN_W-1:0]   chanx_right_in,
    output logic [CHAN_W-1:0]   chanx_left_out,
    output logic [CHAN_W-1:0]   chanx_right_out,
    output logic [NUM_IPIN-1:0] ipin_out,
    output logic                ccff_tail,
    output logic [CNT_W-1:0]    cfg_count,
    output logic                cfg_full,
    output logic                cfg_valid,
    output logic                cfg_err
);

    localparam int N     = NUM_IPIN * SEL_W;
    localparam int MUX_N = 2 * CHAN_W;

    generate
        if (CHAN_W < 1 || CHAN_W > 16) begin : g_bad_chan_w
            $error("cb_cfg_shadow_param: CHAN_W must be in 1..16");
        end
        if ((1 << SEL_W) <= MUX_N) begin : g_bad_sel_w
            $error("cb_cfg_shadow_param: 2**SEL_W must exceed 2*CHAN_W");
        end
        if ((1 << CNT_W) <= N) begin : g_bad_cnt_w
            $error("cb_cfg_shadow_param: 2**CNT_W must exceed NUM_IPIN*SEL_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOADING = 2'd1,
        S_FULL    = 2'd2
    } load_state_t;

    logic [N-1:0]      sr_q;
    logic [N-1:0]      act_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              valid_q;
    logic              err_q;
    load_state_t       state;
    logic              commit_ok;
    logic              err_set;
    logic [MUX_N-1:0]  mux_in;

    // State register: the load state is carried entirely by the bit counter
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            sr_q    <= '0;
            act_q   <= '1;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_nxt;
            if (ccff_en) begin
                sr_q <= {sr_q[N-2:0], ccff_head};
            end
            if (commit_ok) begin
                act_q   <= sr_q;
                valid_q <= 1'b1;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // Next-state: a shift always wins over a same-cycle commit, which is then flagged
    always_comb begin
        cnt_nxt   = cnt_q;
        commit_ok = 1'b0;
        err_set   = 1'b0;
        if (ccff_en) begin
            if (state != S_FULL) begin
                cnt_nxt = cnt_q + 1'b1;
            end
            err_set = ccff_commit;
        end else if (ccff_commit) begin
            if (state == S_FULL) begin
                commit_ok = 1'b1;
                cnt_nxt   = '0;
            end else begin
                err_set = 1'b1;
            end
        end
    end

    // Output decode of the load state and status flags
    always_comb begin
        state = S_LOADING;
        if (cnt_q == '0) begin
            state = S_IDLE;
        end else if (cnt_q == CNT_W'(N)) begin
            state = S_FULL;
        end
        cfg_full  = (state == S_FULL);
        cfg_count = cnt_q;
        cfg_valid = valid_q;
        cfg_err   = err_q;
        ccff_tail = sr_q[N-1];
    end

    assign chanx_left_out  = chanx_right_in;
    assign chanx_right_out = chanx_left_in;

    // Even mux inputs come from the left tracks, odd ones from the right
    always_comb begin
        mux_in = '0;
        for (int t = 0; t < CHAN_W; t++) begin
            mux_in[2*t]   = chanx_left_in[t];
            mux_in[2*t+1] = chanx_right_in[t];
        end
    end

    // Selects at or above 2*CHAN_W match no input and leave the pin low
    always_comb begin
        ipin_out = '0;
        for (int j = 0; j < NUM_IPIN; j++) begin
            for (int k = 0; k < MUX_N; k++) begin
                if (act_q[j*SEL_W +: SEL_W] == SEL_W'(k)) begin
                    ipin_out[j] = mux_in[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_cb_cfg_shadow_param.sv
// tb/tb_cb_cfg_shadow_param.sv - randomized self-checking bench for cb_cfg_shadow_param
module tb_cb_cfg_shadow_param;

    localparam int CHAN_W   = 3;
    localparam int NUM_IPIN = 4;
    localparam int SEL_W    = 3;
    localparam int CNT_W    = 5;
    localparam int N        = NUM_IPIN * SEL_W;

    logic                prog_clk = 1'b0;
    logic                prog_reset;
    logic                ccff_en;
    logic                ccff_head;
    logic                ccff_commit;
    logic [CHAN_W-1:0]   chanx_left_in;
    logic [CHAN_W-1:0]   chanx_right_in;
    logic [CHAN_W-1:0]   chanx_left_out;
    logic [CHAN_W-1:0]   chanx_right_out;
    logic [NUM_IPIN-1:0] ipin_out;
    logic                ccff_tail;
    logic [CNT_W-1:0]    cfg_count;
    logic                cfg_full;
    logic                cfg_valid;
    logic                cfg_err;

    cb_cfg_shadow_param #(
        .CHAN_W(CHAN_W), .NUM_IPIN(NUM_IPIN), .SEL_W(SEL_W), .CNT_W(CNT_W)
    ) dut (
        .prog_clk(prog_clk), .prog_reset(prog_reset),
        .ccff_en(ccff_en), .ccff_head(ccff_head), .ccff_commit(ccff_commit),
        .chanx_left_in(chanx_left_in), .chanx_right_in(chanx_right_in),
        .chanx_left_out(chanx_left_out), .chanx_right_out(chanx_right_out),
        .ipin_out(ipin_out), .ccff_tail(ccff_tail), .cfg_count(cfg_count),
        .cfg_full(cfg_full), .cfg_valid(cfg_valid), .cfg_err(cfg_err)
    );

    always #5 prog_clk = ~prog_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: bit history of the chain, active selects as one word, flags
    bit m_hist[$];
    int m_act;
    int m_cnt;
    bit m_valid;
    bit m_err;

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int chain_word();
        int w = 0;
        foreach (m_hist[i]) w = (w << 1) | int'(m_hist[i]);
        return w;
    endfunction

    function automatic int exp_tail();
        return (m_hist.size() == N) ? int'(m_hist[0]) : 0;
    endfunction

    function automatic int exp_ipin();
        int r = 0;
        for (int j = 0; j < NUM_IPIN; j++) begin
            int s = (m_act >> (j * SEL_W)) & ((1 << SEL_W) - 1);
            if (s < 2 * CHAN_W) begin
                int src = (s % 2 == 1) ? int'(chanx_right_in) : int'(chanx_left_in);
                r |= ((src >> (s / 2)) & 1) << j;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_act   = (1 << N) - 1;
        m_cnt   = 0;
        m_valid = 0;
        m_err   = 0;
    endtask

    task automatic model_step(input bit en, input bit head, input bit commit);
        if (en) begin
            m_hist.push_back(head);
            if (m_hist.size() > N) void'(m_hist.pop_front());
            if (m_cnt < N) m_cnt++;
            if (commit) m_err = 1;
        end else if (commit) begin
            if (m_cnt == N) begin
                m_act   = chain_word();
                m_cnt   = 0;
                m_valid = 1;
            end else begin
                m_err = 1;
            end
        end
    endtask

    always @(negedge prog_clk) begin
        if (!prog_reset) begin
            chk("cfg_count", int'(cfg_count), m_cnt);
            chk("cfg_full", int'(cfg_full), int'(m_cnt == N));
            chk("cfg_valid", int'(cfg_valid), int'(m_valid));
            chk("cfg_err", int'(cfg_err), int'(m_err));
            chk("ccff_tail", int'(ccff_tail), exp_tail());
            chk("ipin_out", int'(ipin_out), exp_ipin());
            chk("chanx_left_out", int'(chanx_left_out), int'(chanx_right_in));
            chk("chanx_right_out", int'(chanx_right_out), int'(chanx_left_in));
        end
    end

    task automatic step(input bit en, input bit head, input bit commit);
        ccff_en        = en;
        ccff_head      = head;
        ccff_commit    = commit;
        chanx_left_in  = CHAN_W'($urandom);
        chanx_right_in = CHAN_W'($urandom);
        @(posedge prog_clk);
        model_step(en, head, commit);
        #1;
        ccff_en     = 1'b0;
        ccff_commit = 1'b0;
    endtask

    task automatic shift_word(input int v, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) step(1'b1, bit'((v >> i) & 1), 1'b0);
    endtask

    task automatic set_chan(input int l, input int r);
        chanx_left_in  = CHAN_W'(l);
        chanx_right_in = CHAN_W'(r);
        #1;
    endtask

    task automatic do_reset();
        #1;
        prog_reset  = 1'b1;
        ccff_en     = 1'b0;
        ccff_commit = 1'b0;
        #1;
        model_reset();
        chk("reset_count_now", int'(cfg_count), 0);
        chk("reset_ipin_now", int'(ipin_out), 0);
        @(negedge prog_clk);
        #1;
        prog_reset = 1'b0;
    endtask

    initial begin
        prog_reset     = 1'b1;
        ccff_en        = 1'b0;
        ccff_head      = 1'b0;
        ccff_commit    = 1'b0;
        chanx_left_in  = '0;
        chanx_right_in = '0;
        model_reset();
        repeat (2) @(posedge prog_clk);
        #1;
        chk("init_count", int'(cfg_count), 0);
        chk("init_ipin", int'(ipin_out), 0);
        chk("init_tail", int'(ccff_tail), 0);
        @(negedge prog_clk);
        #1;
        prog_reset = 1'b0;

        // Reset mid-load
        shift_word('h1F, 5);
        chk("midload_count", int'(cfg_count), 5);
        do_reset();
        chk("post_reset_valid", int'(cfg_valid), 0);
        chk("post_reset_tail", int'(ccff_tail), 0);

        // Full load: sel_3=7, sel_2=4, sel_1=3, sel_0=0
        shift_word('b111_100_011_000, N);
        chk("full_before_commit", int'(cfg_full), 1);
        set_chan('b111, 'b111);
        chk("ipin_before_commit", int'(ipin_out), 0);
        step(1'b0, 1'b0, 1'b1);
        set_chan('b101, 'b010);
        chk("load1_ipin_a", int'(ipin_out), 'b0111);
        set_chan('b010, 'b101);
        chk("load1_ipin_b", int'(ipin_out), 'b0000);
        chk("load1_valid", int'(cfg_valid), 1);
        chk("load1_count", int'(cfg_count), 0);
        chk("load1_err", int'(cfg_err), 0);

        // Premature commit, then completion
        shift_word('b1010101, 7);
        step(1'b0, 1'b0, 1'b1);
        chk("premature_err", int'(cfg_err), 1);
        chk("premature_count", int'(cfg_count), 7);
        set_chan('b101, 'b010);
        chk("premature_act_kept", int'(ipin_out), 'b0111);
        shift_word('b00000, 5);
        step(1'b0, 1'b0, 1'b1);
        chk("late_commit_valid", int'(cfg_valid), 1);
        chk("late_commit_err", int'(cfg_err), 1);

        // Overshift: 1,0,1 then selects 5,2,1,0
        shift_word('b101, 3);
        shift_word('b101_010_001_000, N);
        chk("overshift_count", int'(cfg_count), N);
        step(1'b0, 1'b0, 1'b1);
        set_chan('b011, 'b001);
        chk("overshift_ipin", int'(ipin_out), 'b0111);

        // Tail order of the first three bits
        do_reset();
        shift_word('b101, 3);
        shift_word(0, N - 3);
        chk("tail_bit1", int'(ccff_tail), 1);
        step(1'b1, 1'b0, 1'b0);
        chk("tail_bit2", int'(ccff_tail), 0);
        step(1'b1, 1'b0, 1'b0);
        chk("tail_bit3", int'(ccff_tail), 1);

        // Shift and commit together while full
        do_reset();
        shift_word('b000_001_010_011, N);
        step(1'b1, 1'b1, 1'b1);
        chk("simul_err", int'(cfg_err), 1);
        chk("simul_count", int'(cfg_count), N);
        chk("simul_valid", int'(cfg_valid), 0);
        set_chan('b111, 'b111);
        chk("simul_act_kept", int'(ipin_out), 0);

        // Disable codes on every pin
        shift_word('b111_110_111_110, N);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            set_chan(i, 7 - i);
            chk("disabled_ipin", int'(ipin_out), 0);
        end

        // Randomized traffic with the occasional reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                     bit'($urandom_range(0, 7) == 0));
            end
        end

        @(negedge prog_clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
